loadstore: RTL

Memory-access stage that sits directly downstream of the execute stage and directly upstream of write-back. It accepts one instruction per handshake from execute. Loads and stores are turned into single pipelined Wishbone B4 master transactions, with lane alignment and load sign/zero extension. Non-memory instructions pass through to write-back with one cycle of latency.

---
 rtl/loadstore.sv | 128 ++++++++++++
 1 files changed

// File: rtl/loadstore.sv
// loadstore: memory-access stage between execute and write-back.
// Pipelined Wishbone B4 master with lane alignment and load extension.
module loadstore (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        input_ready_o,
  input  logic        input_valid_i,
  input  logic [31:0] result_i,
  input  logic        ls_enable_i,
  input  logic        ls_write_i,
  input  logic [31:0] ls_write_data_i,
  input  logic [3:0]  ls_sel_i,
  input  logic        ls_unsigned_load_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  output logic        output_valid_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQUEST  = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;

  logic [1:0]  state;
  logic [1:0]  off_q;
  logic [3:0]  size_q;
  logic        uns_q;
  logic        rw_q;
  logic [4:0]  ra_q;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        done;

  assign input_ready_o = (state == IDLE);
  assign shifted = wb_dat_i >> {off_q, 3'b000};
  assign done = ((state == REQUEST) && !wb_stall_i && wb_ack_i)
             || ((state == WAIT_ACK) && wb_ack_i);

  always_comb begin
    load_data = shifted;
    unique case (1'b1)
      size_q[3]:
        load_data = shifted;
      size_q[1] & ~size_q[3]:
        load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default:
        load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      off_q          <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      rw_q           <= 1'b0;
      ra_q           <= '0;
      wb_adr_o       <= '0;
      wb_dat_o       <= '0;
      wb_sel_o       <= '0;
      wb_we_o        <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_cyc_o       <= 1'b0;
      output_valid_o <= 1'b0;
      reg_write_o    <= 1'b0;
      reg_addr_o     <= '0;
      reg_data_o     <= '0;
    end else begin
      output_valid_o <= 1'b0;
      reg_write_o    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (input_valid_i && ls_enable_i) begin
            wb_adr_o <= {result_i[31:2], 2'b00};
            wb_dat_o <= ls_write_data_i << {result_i[1:0], 3'b000};
            wb_sel_o <= ls_sel_i << result_i[1:0];
            wb_we_o  <= ls_write_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            off_q    <= result_i[1:0];
            size_q   <= ls_sel_i;
            uns_q    <= ls_unsigned_load_i;
            rw_q     <= reg_write_i;
            ra_q     <= reg_addr_i;
            state    <= REQUEST;
          end else if (input_valid_i) begin
            output_valid_o <= 1'b1;
            reg_write_o    <= reg_write_i;
            reg_addr_o     <= reg_addr_i;
            reg_data_o     <= result_i;
          end
        end
        REQUEST: begin
          if (!wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: ;
        default: state <= IDLE;
      endcase
      // completion overrides whatever the state step chose
      if (done) begin
        state          <= IDLE;
        wb_stb_o       <= 1'b0;
        wb_cyc_o       <= 1'b0;
        wb_we_o        <= 1'b0;
        output_valid_o <= 1'b1;
        reg_write_o    <= rw_q & ~wb_we_o;
        reg_addr_o     <= ra_q;
        reg_data_o     <= load_data;
      end
    end
  end

endmodule
